// File: rtl/i2s2_rx_deserializer_if.sv
// Sample-pair stream leaving the I2S2 receive front end: one left/right
// pair per LRCK frame, valid/ready handshake, producer holds data while
// valid is high and not accepted.
interface i2s2_rx_deserializer_if #(
    parameter int DATA_WIDTH = 24
) ();
    logic [DATA_WIDTH-1:0] m_left;
    logic [DATA_WIDTH-1:0] m_right;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output m_left,
        output m_right,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_left,
        input  m_right,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/i2s2_rx_deserializer.sv
// I2S2 PMOD ADC receive front end. Generates MCLK/SCLK/LRCK from clk with a
// free-running 9-bit counter, samples rx_data mid-SCLK-high, assembles one
// left/right pair per frame and presents it through a single holding
// register. A pair arriving while the previous one is still unaccepted is
// dropped and flagged on the sticky overflow bit.
module i2s2_rx_deserializer #(
    parameter int DATA_WIDTH = 24
) (
    input  logic clk,
    input  logic rst,
    output logic rx_mclk,
    output logic rx_lrck,
    output logic rx_sclk,
    input  logic rx_data,
    input  logic ovf_clr,
    output logic overflow,
    i2s2_rx_deserializer_if.master m
);
    localparam logic [4:0] LAST_SLOT = 5'(DATA_WIDTH);

    logic [8:0]            count;
    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] sr_next;
    logic [DATA_WIDTH-1:0] left_hold;
    logic [DATA_WIDTH-1:0] left_q;
    logic [DATA_WIDTH-1:0] right_q;
    logic                  valid_q;

    logic [4:0] slot;
    logic       strobe;
    logic       in_word;
    logic       left_done;
    logic       load;

    assign rx_mclk = clk;
    assign rx_lrck = count[8];
    assign rx_sclk = count[2];

    assign slot      = count[7:3];
    // Middle of SCLK high: the codec changed the line on the previous fall.
    assign strobe    = (count[2:0] == 3'b101);
    // Slot 0 is the I2S delay bit; slots past the word are padding.
    assign in_word   = strobe && (slot != 5'd0) && (slot <= LAST_SLOT);
    assign left_done = strobe && !count[8] && (slot == LAST_SLOT);
    // The right LSB strobe: the pair is complete once this bit is shifted in,
    // so it is taken from sr_next and appears on the outputs one clk later.
    assign load      = strobe &&  count[8] && (slot == LAST_SLOT);

    generate
        if (DATA_WIDTH == 1) begin : g_sr1
            assign sr_next = rx_data;
        end else begin : g_srn
            assign sr_next = {sr[DATA_WIDTH-2:0], rx_data};
        end
    endgenerate

    assign m.m_left  = left_q;
    assign m.m_right = right_q;
    assign m.m_valid = valid_q;

    // Free-running frame counter; all codec clocks are decoded from it.
    always_ff @(posedge clk) begin
        if (rst) count <= 9'd0;
        else     count <= count + 9'd1;
    end

    // MSB-first shift of in-word bits; left word parked at its last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            left_hold <= '0;
        end else begin
            if (in_word)   sr        <= sr_next;
            if (left_done) left_hold <= sr_next;
        end
    end

    // Single-entry output register with drop-on-full and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            left_q   <= '0;
            right_q  <= '0;
            valid_q  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (load) begin
                if (!valid_q || m.m_ready) begin
                    left_q  <= left_hold;
                    right_q <= sr_next;
                    valid_q <= 1'b1;
                end
            end else if (valid_q && m.m_ready) begin
                valid_q <= 1'b0;
            end
            // Clear first so a same-cycle drop still leaves the flag set.
            if (ovf_clr) overflow <= 1'b0;
            if (load && valid_q && !m.m_ready) overflow <= 1'b1;
        end
    end
endmodule
